// File: rtl/adaptive_uart_pkg.sv
// Shared definitions for the adaptive UART SerDes: the receive FSM states,
// the frame widths, and the Hamming(12,8) data-bit positions.
package adaptive_uart_pkg;

  localparam int CODEWORD_W = 12;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DECODE = 3'd5
  } rx_state_t;

  // 1-based Hamming positions of d0..d7
  localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

endpackage

// File: rtl/hamming12_8_decoder.sv
// Combinational Hamming(12,8) decoder: computes the syndrome, corrects a single
// flipped position, and flags syndromes 13-15 as uncorrectable (data passes raw).
module hamming12_8_decoder
  import adaptive_uart_pkg::*;
(
  input  logic [CODEWORD_W-1:0] i_codeword,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_err_corrected,
  output logic                  o_err_uncorrectable
);

  logic [3:0]            w_syn;
  logic [CODEWORD_W-1:0] w_fixed;

  always_comb begin
    w_syn   = '0;
    w_fixed = i_codeword;
    o_data  = '0;
    for (int p = 1; p <= CODEWORD_W; p++) begin
      if (i_codeword[p-1]) w_syn = w_syn ^ 4'(p);
    end
    for (int p = 1; p <= CODEWORD_W; p++) begin
      if (w_syn == 4'(p)) w_fixed[p-1] = ~i_codeword[p-1];
    end
    o_err_corrected     = (w_syn != 4'd0) && (w_syn <= 4'(CODEWORD_W));
    o_err_uncorrectable = (w_syn > 4'(CODEWORD_W));
    for (int i = 0; i < DATA_W; i++) begin
      o_data[i] = w_fixed[DATA_POS[i]-1];
    end
  end

endmodule

// File: rtl/adaptive_uart_rx_deserializer.sv
// UART receiver for Hamming(12,8) frames: start, 12 bits LSB first, optional
// parity (RX_PARITY_EN), stop. Strobes the corrected byte one cycle after the stop sample.
module adaptive_uart_rx_deserializer
  import adaptive_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  idle_mode,
  output logic [DATA_W-1:0]     data_8b_out,
  output logic                  data_valid,
  output logic [CODEWORD_W-1:0] encoded_data,
  output logic                  err_corrected,
  output logic                  err_uncorrectable,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(CODEWORD_W - 1);

  rx_state_t             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_rx_d;
  logic                  r_armed;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_bit;
  logic [CODEWORD_W-1:0] r_cw;
  logic [DATA_W-1:0]     r_data;
  logic [CODEWORD_W-1:0] r_enc;
  logic                  r_corr;
  logic                  r_uncorr;
  logic                  r_frame_err;
  logic                  r_data_valid;
`ifdef RX_PARITY_EN
  logic                  r_par_bit;
  logic                  r_parity_err;
`endif

  logic                  w_rx;
  logic                  w_tick;
  logic [DATA_W-1:0]     w_dec_data;
  logic                  w_dec_corr;
  logic                  w_dec_uncorr;

  assign w_rx   = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_cnt == FULL_TC);

  hamming12_8_decoder u_dec (
    .i_codeword          (r_cw),
    .o_data              (w_dec_data),
    .o_err_corrected     (w_dec_corr),
    .o_err_uncorrectable (w_dec_uncorr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= '1;
      r_rx_d       <= 1'b1;
      r_armed      <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_cw         <= '0;
      r_data       <= '0;
      r_enc        <= '0;
      r_corr       <= 1'b0;
      r_uncorr     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_data_valid <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_sync[0] <= rx;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_rx_d       <= w_rx;
      r_data_valid <= 1'b0;
      if (w_rx) r_armed <= 1'b1;

      // idle_mode overrides any terminal count reached this cycle
      if (idle_mode) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_armed && r_rx_d && !w_rx) begin
              r_state <= START;
              r_cnt   <= '0;
            end
          end
          START: begin
            if (r_cnt == HALF_TC) begin
              r_cnt   <= '0;
              r_bit   <= '0;
              r_state <= w_rx ? IDLE : DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DATA: begin
            if (w_tick) begin
              r_cnt       <= '0;
              r_cw[r_bit] <= w_rx;
              if (r_bit == LAST_BIT) begin
`ifdef RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (w_tick) begin
              r_cnt     <= '0;
              r_par_bit <= w_rx;
              r_state   <= STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (w_tick) begin
              r_cnt        <= '0;
              r_data       <= w_dec_data;
              r_enc        <= r_cw;
              r_corr       <= w_dec_corr;
              r_uncorr     <= w_dec_uncorr;
              r_frame_err  <= ~w_rx;
              r_data_valid <= 1'b1;
`ifdef RX_PARITY_EN
              r_parity_err <= r_par_bit ^ (^r_cw);
`endif
              // a low stop bit may be a break: wait for the line to go high again
              if (!w_rx) r_armed <= 1'b0;
              r_state <= DECODE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DECODE:  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_8b_out       = r_data;
  assign data_valid        = r_data_valid;
  assign encoded_data      = r_enc;
  assign err_corrected     = r_corr;
  assign err_uncorrectable = r_uncorr;
  assign frame_err         = r_frame_err;
  assign busy              = (r_state != IDLE);
`ifdef RX_PARITY_EN
  assign parity_err        = r_parity_err;
`else
  assign parity_err        = 1'b0;
`endif

endmodule
